burst_mem_responder: RTL
========================

Name: burst_mem_responder

Overview:
- Memory-side responder for the burst memory interface driven by the cache line adapter (the SERIALIZE/DESERIALIZE initiator).
- Accepts one line request at a time.
  - Read: returns a full line as BURST_LEN data beats after a fixed latency.
  - Write: absorbs BURST_LEN data beats and commits the line.
- Used as the synthesizable backing memory under the I/D caches in block-level and top-level benches.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 64, bits per beat.
- BURST_LEN, 4, beats per cache line (line = 256 bits, 32 bytes).
- NUM_LINES, 256, lines of backing storage; power of two.
- READ_LATENCY, 8, cycles from read acceptance to first data beat; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- bmem_addr  in  ADDR_WIDTH  request byte address; low log2(BURST_LEN*DATA_WIDTH/8) bits ignored.
- bmem_read  in  1  read request.
- bmem_write  in  1  write request / write beat valid.
- bmem_wdata  in  DATA_WIDTH  write beat data.
- bmem_ready  out  1  responder can accept a new request.
- bmem_raddr  out  ADDR_WIDTH  line-aligned address of the returning read.
- bmem_rdata  out  DATA_WIDTH  read beat data.
- bmem_rvalid  out  1  read beat valid.
- proto_err  out  1  sticky protocol-violation flag; cleared only by rst.

Behaviour:
- Reset (rst high at edge):
  - State -> RIDLE.
  - bmem_ready=1, bmem_rvalid=0, bmem_rdata=0, bmem_raddr=0, proto_err=0.
  - Latency counter and beat counter = 0.
  - Storage zeroed.
  - Reset mid-burst aborts with no partial commit.
- Line index = bmem_addr[5 +: log2(NUM_LINES)]. Higher address bits are ignored, so addresses wrap. bmem_raddr = request address with low 5 bits zeroed.
- Beat k maps to line bits [k*DATA_WIDTH +: DATA_WIDTH]; beats are sent and received in order k=0..BURST_LEN-1.
- Request acceptance: only in RIDLE, where bmem_ready=1. Request signals sampled while bmem_ready=0 are ignored, except write beats in RWBURST.
- RIDLE, bmem_read=1, bmem_write=0 at edge E0:
  - Latch index and aligned address.
  - Go to RLATENCY with counter = READ_LATENCY-1.
  - bmem_ready=0 from E0 onward.
- RLATENCY:
  - Counter decrements each edge.
  - At counter==0, go to RBURST.
  - First beat (rvalid=1) is visible in the cycle following edge E0+READ_LATENCY.
- RBURST:
  - bmem_rvalid=1 for exactly BURST_LEN consecutive cycles, with beat 0..BURST_LEN-1 on bmem_rdata.
  - bmem_raddr is constant through the burst.
  - After the last beat: rvalid=0 and bmem_ready=1 in the same cycle (state RIDLE).
  - No backpressure on beats.
- RIDLE, bmem_write=1, bmem_read=0 at edge E0:
  - Beat 0 is captured at E0 into a line buffer.
  - Go to RWBURST with beat counter=1; bmem_ready=0.
- RWBURST:
  - bmem_write must be high on each of the next BURST_LEN-1 consecutive edges; each edge captures the next beat.
  - On the final beat's edge, the full line is written to storage; return to RIDLE with bmem_ready=1 next cycle.
  - No response beat is generated for writes.
- Write commit visibility: a read accepted any time after commit returns the new data.
- Protocol errors, all of which set proto_err=1:
  - bmem_read and bmem_write both high in RIDLE: request ignored, stay RIDLE.
  - bmem_write low during RWBURST: write aborted, storage unchanged, return to RIDLE.
  - bmem_read high during RWBURST: treated as the same abort.
- Counter widths: latency counter $clog2(READ_LATENCY+1) bits; beat counter $clog2(BURST_LEN) bits (minimum 1 bit); wrap of the beat counter at BURST_LEN-1 defines the end of a burst.

Decomposition:
- Add to the shared cache types package:
  - enum bit [1:0] responder_state_t {RIDLE, RLATENCY, RBURST, RWBURST}.
  - Localparams LINE_BYTES=32 and OFFSET_BITS=5, shared with the line adapter.
- One sub-module: mem_line_array. Line-wide storage (NUM_LINES x BURST_LEN*DATA_WIDTH), synchronous write, combinational read of the latched index, synchronous zeroing on rst.
- The FSM, counters and line buffer live in burst_mem_responder.

Test Plan:
- Write then read:
  - Stimulus: write 0x40 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44; then read 0x40.
  - Required: rvalid high 4 cycles with the same beats in order, raddr=0x40, first beat exactly 8 cycles after read acceptance.
- Misaligned/wrap:
  - Stimulus: read 0x2047 after writing line 0x47&~0x1F (0x40) with NUM_LINES=256.
  - Required: raddr=0x2040; data equals line 0x40 data (index wraps).
- Back-to-back:
  - Stimulus: read issued the cycle bmem_ready returns after a prior read.
  - Required: accepted; no idle gap beyond ready-high cycle; ready low during both latency windows.
- Aborted write:
  - Stimulus: write 0x80, drop bmem_write after beat 1.
  - Required: proto_err=1; subsequent read of 0x80 returns zeros; ready=1 the cycle after abort.
- Simultaneous read+write in RIDLE:
  - Required: proto_err=1, no rvalid ever, storage unchanged.
- Reset at second read beat:
  - Required: next cycle rvalid=0, ready=1, proto_err=0; storage zero.

Source files
------------

// File: rtl/burst_mem_responder_pkg.sv
// Shared cache types: responder FSM states and line geometry constants.
package burst_mem_responder_pkg;

  typedef enum bit [1:0] {
    RIDLE,
    RLATENCY,
    RBURST,
    RWBURST
  } responder_state_t;

  localparam int LINE_BYTES  = 32;
  localparam int OFFSET_BITS = 5;

endpackage

// File: rtl/mem_line_array.sv
// Line-wide backing storage: synchronous write, combinational read of the
// latched read index, synchronous zeroing while rst is high.
module mem_line_array #(
  parameter int NUM_LINES = 256,
  parameter int LINE_W    = 256,
  parameter int IDX_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [LINE_W-1:0] wline,
  input  logic [IDX_W-1:0]  ridx,
  output logic [LINE_W-1:0] rline
);

  logic [LINE_W-1:0] mem [NUM_LINES];

  // Reset clears every line; otherwise commit a whole line when requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[widx] <= wline;
    end
  end

  assign rline = mem[ridx];

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the burst line interface: one line request at a
// time, reads returned as BURST_LEN beats after READ_LATENCY cycles, writes
// absorbed as BURST_LEN consecutive beats and committed as a whole line.
module burst_mem_responder
  import burst_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int BURST_LEN    = 4,
  parameter int NUM_LINES    = 256,
  parameter int READ_LATENCY = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] bmem_addr,
  input  logic                  bmem_read,
  input  logic                  bmem_write,
  input  logic [DATA_WIDTH-1:0] bmem_wdata,
  output logic                  bmem_ready,
  output logic [ADDR_WIDTH-1:0] bmem_raddr,
  output logic [DATA_WIDTH-1:0] bmem_rdata,
  output logic                  bmem_rvalid,
  output logic                  proto_err
);

  localparam int LINE_W = BURST_LEN * DATA_WIDTH;
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int LAT_W  = $clog2(READ_LATENCY + 1);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  responder_state_t      state, state_next;
  logic [LAT_W-1:0]      lat_cnt, lat_next;
  logic [BEAT_W-1:0]     beat_cnt, beat_next, wbeat;
  logic [IDX_W-1:0]      idx_q, idx_next, widx;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_next;
  logic                  err_q, err_next;
  logic                  buf_we, mem_we;
  logic [LINE_W-1:0]     line_buf, line_merge, rline;
  logic [IDX_W-1:0]      addr_idx;
  logic [ADDR_WIDTH-1:0] addr_aligned;
  logic                  unused_addr;

  // Offset bits select a byte within the line; bits above the index wrap.
  assign addr_idx     = bmem_addr[OFFSET_BITS +: IDX_W];
  assign addr_aligned = {bmem_addr[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'(0)};
  assign unused_addr  = ^bmem_addr;

  // Next-state, counter and commit decisions.
  always_comb begin
    state_next = state;
    lat_next   = lat_cnt;
    beat_next  = beat_cnt;
    idx_next   = idx_q;
    raddr_next = raddr_q;
    err_next   = err_q;
    buf_we     = 1'b0;
    mem_we     = 1'b0;
    widx       = idx_q;
    wbeat      = beat_cnt;
    case (state)
      RIDLE: begin
        wbeat = '0;
        widx  = addr_idx;
        if (bmem_read && bmem_write) begin
          err_next = 1'b1;
        end else if (bmem_read) begin
          idx_next   = addr_idx;
          raddr_next = addr_aligned;
          lat_next   = LAT_W'(READ_LATENCY - 1);
          state_next = RLATENCY;
        end else if (bmem_write) begin
          idx_next = addr_idx;
          buf_we   = 1'b1;
          if (LAST_BEAT == '0) begin
            mem_we = 1'b1;
          end else begin
            beat_next  = BEAT_W'(1);
            state_next = RWBURST;
          end
        end
      end
      RLATENCY: begin
        if (lat_cnt == '0) begin
          beat_next  = '0;
          state_next = RBURST;
        end else begin
          lat_next = lat_cnt - 1'b1;
        end
      end
      RBURST: begin
        if (beat_cnt == LAST_BEAT) begin
          beat_next  = '0;
          state_next = RIDLE;
        end else begin
          beat_next = beat_cnt + 1'b1;
        end
      end
      RWBURST: begin
        // Any gap in write beats, or a read mid-burst, drops the whole line.
        if (bmem_write && !bmem_read) begin
          buf_we = 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            mem_we     = 1'b1;
            beat_next  = '0;
            state_next = RIDLE;
          end else begin
            beat_next = beat_cnt + 1'b1;
          end
        end else begin
          err_next   = 1'b1;
          beat_next  = '0;
          state_next = RIDLE;
        end
      end
      default: state_next = RIDLE;
    endcase
  end

  // Splice the incoming write beat into the partially assembled line.
  always_comb begin
    line_merge = line_buf;
    line_merge[int'(wbeat) * DATA_WIDTH +: DATA_WIDTH] = bmem_wdata;
  end

  // Control state register; reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RIDLE;
      lat_cnt  <= '0;
      beat_cnt <= '0;
      idx_q    <= '0;
      raddr_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_next;
      lat_cnt  <= lat_next;
      beat_cnt <= beat_next;
      idx_q    <= idx_next;
      raddr_q  <= raddr_next;
      err_q    <= err_next;
    end
  end

  // Write line buffer: data only, its contents matter only once complete.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      line_buf <= line_merge;
    end
  end

  mem_line_array #(
    .NUM_LINES (NUM_LINES),
    .LINE_W    (LINE_W),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .widx  (widx),
    .wline (line_merge),
    .ridx  (idx_q),
    .rline (rline)
  );

  // Read beat mux; rdata is held at zero outside a read burst.
  always_comb begin
    bmem_rdata = '0;
    if (state == RBURST) begin
      bmem_rdata = rline[int'(beat_cnt) * DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bmem_ready  = (state == RIDLE);
  assign bmem_rvalid = (state == RBURST);
  assign bmem_raddr  = raddr_q;
  assign proto_err   = err_q;

endmodule
